udp_seq_eval: RTL

- Hardware evaluator for sequential user-defined-primitive tables: the reader/executor for the tables our UDP parser accepts.
- A table of encoded rows is written through a load port. Each new input vector is then resolved against the table by a row-scan state machine, which produces the next registered output q.
- Used as a reference engine for UDP semantics checks: level symbols, edge pairs, r/f/p/n/*, and output 0/1/x/-.

---
 rtl/udp_eval_pkg.sv | 63 ++++++
 rtl/udp_row_match.sv | 46 ++++
 rtl/udp_seq_eval.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/udp_eval_pkg.sv
`default_nettype none
// ============================================================================
// Module   : udp_eval_pkg
// Brief    : Encodings, symbol masks, row layout helpers and FSM states for
//            the sequential UDP table evaluator.
// Revision : 1.0
// ============================================================================
package udp_eval_pkg;

    // Two-bit input/output value codes
    localparam logic [1:0] V_0 = 2'b00;
    localparam logic [1:0] V_1 = 2'b01;
    localparam logic [1:0] V_X = 2'b10;

    // Value-set masks: bit0 = 0, bit1 = 1, bit2 = x
    localparam logic [2:0] M_0   = 3'b001;
    localparam logic [2:0] M_1   = 3'b010;
    localparam logic [2:0] M_X   = 3'b100;
    localparam logic [2:0] M_ALL = 3'b111;

    // Row output codes; OUT_NC keeps the current state
    localparam logic [1:0] OUT_0  = 2'b00;
    localparam logic [1:0] OUT_1  = 2'b01;
    localparam logic [1:0] OUT_X  = 2'b10;
    localparam logic [1:0] OUT_NC = 2'b11;

    // Input field encodings {chg, from_mask, to_mask}
    localparam logic [6:0] SYM_R    = {1'b0, M_0, M_1};
    localparam logic [6:0] SYM_F    = {1'b0, M_1, M_0};
    localparam logic [6:0] SYM_P    = {1'b1, 3'b101, 3'b110};
    localparam logic [6:0] SYM_N    = {1'b1, 3'b110, 3'b101};
    localparam logic [6:0] SYM_STAR = {1'b1, M_ALL, M_ALL};
    localparam logic [6:0] LVL_0    = {1'b0, M_ALL, M_0};
    localparam logic [6:0] LVL_1    = {1'b0, M_ALL, M_1};
    localparam logic [6:0] LVL_X    = {1'b0, M_ALL, M_X};
    localparam logic [6:0] LVL_B    = {1'b0, M_ALL, 3'b011};
    localparam logic [6:0] LVL_Q    = {1'b0, M_ALL, M_ALL};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of input field idx inside a row; state mask and out sit below
    function automatic int field_lsb(input int idx);
        return 5 + 7 * idx;
    endfunction

    function automatic logic [2:0] val2mask(input logic [1:0] v);
        case (v)
            V_0:     return M_0;
            V_1:     return M_1;
            default: return M_X;
        endcase
    endfunction

    function automatic logic [1:0] norm_val(input logic [1:0] v);
        return (v == 2'b11) ? V_X : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/udp_row_match.sv
`default_nettype none
// ============================================================================
// Module   : udp_row_match
// Brief    : Combinational matcher of one table row against the input view
//            seen while input k is being processed.
// Revision : 1.0
// ============================================================================
module udp_row_match
    import udp_eval_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int KW   = 1
) (
    input  logic [7*N_IN+4:0] row,
    input  logic [2*N_IN-1:0] prev,
    input  logic [2*N_IN-1:0] cur,
    input  logic [KW-1:0]     k,
    input  logic [1:0]        q,
    output logic              match
);

    logic [N_IN-1:0] w_ok;

    generate
        for (genvar j = 0; j < N_IN; j++) begin : g_field
            logic [6:0] w_fld;
            logic [1:0] w_p;
            logic [1:0] w_c;
            logic       w_edge;

            assign w_fld  = row[field_lsb(j) +: 7];
            assign w_edge = w_fld[6] || (w_fld[5:3] != M_ALL);
            // Inputs below k already show new values, inputs above k still old
            assign w_p = (KW'(j) <  k) ? cur[2*j +: 2] : prev[2*j +: 2];
            assign w_c = (KW'(j) <= k) ? cur[2*j +: 2] : prev[2*j +: 2];
            assign w_ok[j] = (|(val2mask(w_p) & w_fld[5:3]))
                          && (|(val2mask(w_c) & w_fld[2:0]))
                          && (!w_fld[6] || (w_p != w_c))
                          && (!w_edge || (KW'(j) == k));
        end
    endgenerate

    assign match = (&w_ok) && (|(val2mask(q) & row[4:2]));

endmodule
`default_nettype wire

// File: rtl/udp_seq_eval.sv
`default_nettype none
// ============================================================================
// Module   : udp_seq_eval
// Brief    : Sequential UDP table evaluator: loadable row table plus a
//            one-row-per-cycle scan FSM producing the registered output q.
// Revision : 1.0
// ============================================================================
module udp_seq_eval
    import udp_eval_pkg::*;
#(
    parameter int N_IN  = 2,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [7*N_IN+4:0]   wr_data,
    input  logic [AW:0]         nrows,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*N_IN-1:0]   in_val,
    output logic                out_valid,
    output logic [1:0]          q,
    output logic                hit,
    output logic [AW-1:0]       hit_row,
    output logic                wr_err
);

    localparam int         RW    = 7 * N_IN + 5;
    localparam int         KW    = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [AW:0] C_ONE = (AW + 1)'(1);

    logic [RW-1:0]     r_table [DEPTH];
    state_t            r_state;
    logic [2*N_IN-1:0] r_prev;
    logic [2*N_IN-1:0] r_cur;
    logic [N_IN-1:0]   r_pend;
    logic [KW-1:0]     r_k;
    logic [AW:0]       r_row;
    logic [AW:0]       r_nrows;

    logic [2*N_IN-1:0] w_in_norm;
    logic [N_IN-1:0]   w_changed;
    logic [N_IN-1:0]   w_rest;
    logic [RW-1:0]     w_row;
    logic              w_match;
    logic              w_in_range;
    logic              w_last;
    logic              w_hit;

    function automatic logic [KW-1:0] lowest(input logic [N_IN-1:0] v);
        lowest = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (v[i]) lowest = KW'(i);
        end
    endfunction

    generate
        for (genvar i = 0; i < N_IN; i++) begin : g_norm
            assign w_in_norm[2*i +: 2] = norm_val(in_val[2*i +: 2]);
            assign w_changed[i]        = (w_in_norm[2*i +: 2] != r_prev[2*i +: 2]);
        end
    endgenerate

    assign in_ready   = (r_state == IDLE);
    assign w_rest     = r_pend & ~(N_IN'(1) << r_k);
    assign w_row      = r_table[r_row[AW-1:0]];
    assign w_in_range = (r_row < r_nrows);
    assign w_last     = ((r_row + C_ONE) >= r_nrows);
    assign w_hit      = w_in_range && w_match;

    udp_row_match #(
        .N_IN (N_IN),
        .KW   (KW)
    ) u_match (
        .row   (w_row),
        .prev  (r_prev),
        .cur   (r_cur),
        .k     (r_k),
        .q     (q),
        .match (w_match)
    );

    // Table is writable only while idle; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en && (r_state == IDLE)) begin
            r_table[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            q         <= V_X;
            r_prev    <= {N_IN{V_X}};
            r_cur     <= {N_IN{V_X}};
            r_pend    <= '0;
            r_k       <= '0;
            r_row     <= '0;
            r_nrows   <= '0;
            hit       <= 1'b0;
            hit_row   <= '0;
            out_valid <= 1'b0;
            wr_err    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            wr_err    <= wr_en && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_cur   <= w_in_norm;
                        r_nrows <= nrows;
                        r_row   <= '0;
                        if (w_changed == '0) begin
                            hit       <= 1'b0;
                            out_valid <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_pend  <= w_changed;
                            r_k     <= lowest(w_changed);
                            r_state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (w_hit || !w_in_range || w_last) begin
                        if (w_hit) begin
                            if (w_row[1:0] != OUT_NC) q <= w_row[1:0];
                            hit     <= 1'b1;
                            hit_row <= r_row[AW-1:0];
                        end else begin
                            q   <= V_X;
                            hit <= 1'b0;
                        end
                        r_prev[{r_k, 1'b0} +: 2] <= r_cur[{r_k, 1'b0} +: 2];
                        r_pend <= w_rest;
                        r_row  <= '0;
                        if (w_rest == '0) begin
                            out_valid <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_k <= lowest(w_rest);
                        end
                    end else begin
                        r_row <= r_row + C_ONE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
